operand_bank: RTL and testbench
===============================

# operand_bank

Parametrised bank of DEPTH load-enabled registers, WIDTH bits each, filled in order from a valid/ready byte stream. It sits between the UART receiver and the ALU and collects a complete operand frame (e.g. A, B, opcode) before the ALU uses it. Once all slots are loaded it holds the frame until the consumer releases it. An optional inter-byte timeout discards a partially received frame.

## Interface
- WIDTH, 8, bits per slot and per input word
- DEPTH, 3, number of slots per frame (≥2)
- TIMEOUT_CYCLES, 100000, idle cycles before a partial frame is aborted (used only with the timeout feature)

- clk  in  1  clock, rising edge
- reset  in  1  reset, asynchronous, active-high
- clear  in  1  synchronous clear: empties the frame and zeroes all slots
- in_valid  in  1  in_data is valid this cycle
- in_data  in  WIDTH  word to be written into the next slot
- in_ready  out  1  bank accepts a word this cycle
- consume  in  1  consumer releases a held frame
- slots  out  DEPTH*WIDTH  flat slot contents; slot i is at [i*WIDTH +: WIDTH]
- fill_count  out  $clog2(DEPTH+1)  number of slots loaded in the current frame
- frame_valid  out  1  level signal: a complete frame is held
- frame_pulse  out  1  one-cycle strobe in the first cycle frame_valid is high
- timeout_err  out  1  one-cycle strobe: a partial frame was aborted

## Operation
- States: FILL and FULL. Reset state is FILL.
- Reset values: slots=0, fill_count=0, frame_valid=0, frame_pulse=0, timeout_err=0, in_ready=1.
- FILL:
  - in_ready=1.
  - A word is accepted on in_valid&&in_ready. It is written to slot[fill_count], and fill_count increments.
  - The accept that makes fill_count reach DEPTH moves the bank to FULL.
- FULL:
  - in_ready=0, frame_valid=1, fill_count=DEPTH.
  - Words presented on in_data are not accepted and have no effect.
  - consume returns the bank to FILL with fill_count=0.
  - Slot contents are retained until they are overwritten.
- consume has no effect in FILL.
- clear has priority over every other input:
  - state goes to FILL, fill_count=0, all slots=0;
  - any word presented in the same cycle is dropped;
  - a clear in FULL also drops frame_valid.
- Slots not yet written in the current frame keep their previous values. Consumers must gate on frame_valid.

## Timing
- slots update on the edge that accepts the word and are visible in the next cycle.
- frame_valid and frame_pulse go high in the cycle after the last accept. frame_pulse lasts exactly one cycle.
- in_ready drops in the same cycle frame_valid rises. It is driven combinationally from the state.
- After consume is sampled, frame_valid=0 and in_ready=1 in the next cycle. A word presented then is accepted into slot 0.
- Back-to-back frames: minimum spacing is DEPTH accept cycles plus 1 consume cycle.
- Reset can be asserted at any point, including mid-frame. All outputs take their reset values immediately and no partial data survives.

## Configuration
- Macro: OPERAND_BANK_TIMEOUT_EN.
- Defined:
  - An idle counter runs in FILL while 0<fill_count<DEPTH. Any accept resets it to 0.
  - When the counter reaches TIMEOUT_CYCLES, on the next edge: fill_count=0 and the counter resets; timeout_err pulses for one cycle; slots are retained.
  - If an accept and the timeout fall on the same edge, the accept wins and no abort occurs.
  - clear and reset zero the counter.
- Undefined: no counter is built, timeout_err is tied to 0, and a partial frame waits indefinitely.

## Structure
- Package operand_bank_pkg holds:
  - the state enum {FILL, FULL};
  - the width localparams for fill_count and the timeout counter.
- Sub-module operand_slot: a single WIDTH-bit flop with asynchronous reset, synchronous clear and load enable, instantiated DEPTH times.
- Slot i has load enable = accept && (fill_count==i).

## Test plan
- Reset, then send 0x12, 0x34, 0x56 on consecutive cycles (WIDTH=8, DEPTH=3) → slots=0x563412, fill_count=3, frame_valid=1, one frame_pulse, in_ready=0.
- While FULL, drive in_valid with 0xFF for 5 cycles, then pulse consume → slots unchanged, frame_valid=0 the next cycle, and 0xAA sent afterwards lands in slot 0.
- After 2 words, assert clear together with in_valid=0x77 → fill_count=0, slots=0, 0x77 is not stored.
- Assert reset asynchronously while fill_count=1 → all outputs return to their reset values before the next clk edge.
- With OPERAND_BANK_TIMEOUT_EN and TIMEOUT_CYCLES=10, send 1 word then idle → timeout_err pulses once after 10 idle cycles and fill_count=0. A word arriving exactly on the timeout edge aborts nothing.
- Without the macro, send 1 word and idle for 1000 cycles → fill_count stays 1 and timeout_err stays 0.

Source files
------------

// File: rtl/operand_bank_pkg.sv
// operand_bank_pkg: shared state type and counter-width helper for the operand bank
package operand_bank_pkg;
  typedef enum logic {FILL, FULL} state_e;
  localparam int DEPTH_DEF = 3;
  localparam int TIMEOUT_DEF = 100000;
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction
endpackage

// File: rtl/operand_slot.sv
// operand_slot: one load-enabled slot register with async reset and sync clear
module operand_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  // clear wins over load so a word arriving with clear is dropped
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= '0;
    else if (clear) q <= '0;
    else if (load) q <= d;
endmodule

// File: rtl/operand_bank.sv
// operand_bank: collects DEPTH words from a valid/ready stream into a held frame; optional idle timeout via OPERAND_BANK_TIMEOUT_EN
module operand_bank
  import operand_bank_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int DEPTH          = DEPTH_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  input  logic                       consume,
  output logic [DEPTH*WIDTH-1:0]     slots,
  output logic [$clog2(DEPTH+1)-1:0] fill_count,
  output logic                       frame_valid,
  output logic                       frame_pulse,
  output logic                       timeout_err
);
  localparam int FW = cnt_w(DEPTH);
  state_e state_q, state_d;
  logic [FW-1:0] fill_q, fill_d;
  logic pulse_q, accept, last, abort;
  assign in_ready = state_q == FILL;
  assign accept = in_valid && in_ready && !clear;
  assign last = accept && fill_q == FW'(DEPTH - 1);
  assign fill_count = fill_q;
  assign frame_valid = state_q == FULL;
  assign frame_pulse = pulse_q;
`ifdef OPERAND_BANK_TIMEOUT_EN
  localparam int TW = cnt_w(TIMEOUT_CYCLES);
  logic [TW-1:0] idle_q, idle_d;
  logic err_q;
  assign abort = in_ready && !clear && !accept && fill_q != '0 && idle_q == TW'(TIMEOUT_CYCLES);
  assign timeout_err = err_q;
  // idle counter only runs while a partial frame is waiting
  always_comb
    idle_d = (clear || accept || abort || !in_ready || fill_q == '0) ? '0 : idle_q + 1'b1;
  // idle counter and abort strobe
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      idle_q <= '0;
      err_q  <= 1'b0;
    end else begin
      idle_q <= idle_d;
      err_q  <= abort;
    end
`else
  assign abort = 1'b0;
  assign timeout_err = 1'b0;
`endif
  // next state and fill level; clear overrides everything
  always_comb begin
    state_d = clear ? FILL : in_ready ? (last ? FULL : FILL) : (consume ? FILL : FULL);
    fill_d = clear ? '0 : !in_ready ? (consume ? '0 : fill_q) : accept ? fill_q + 1'b1 : abort ? '0 : fill_q;
  end
  // FILL/FULL state, fill level and frame strobe
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= FILL;
      fill_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      pulse_q <= last;
    end
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    operand_slot #(.WIDTH(WIDTH)) u_slot (
      .clk  (clk),
      .reset(reset),
      .clear(clear),
      .load (accept && fill_q == FW'(i)),
      .d    (in_data),
      .q    (slots[i*WIDTH +: WIDTH])
    );
  end
endmodule

// File: tb/tb_operand_bank.sv
// tb_operand_bank: directed checks of fill, hold, consume, clear, async reset and idle timeout
module tb_operand_bank;
  logic clk = 1'b0, reset = 1'b1, clear = 1'b0, in_valid = 1'b0, consume = 1'b0;
  logic [7:0] in_data = '0;
  logic in_ready, frame_valid, frame_pulse, timeout_err;
  logic [23:0] slots;
  logic [1:0] fill_count;
  int checks = 0, errors = 0, n;
  operand_bank #(.WIDTH(8), .DEPTH(3), .TIMEOUT_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .consume(consume), .slots(slots), .fill_count(fill_count),
    .frame_valid(frame_valid), .frame_pulse(frame_pulse), .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] d);
    in_valid = 1'b1;
    in_data = d;
    tick();
    in_valid = 1'b0;
  endtask
  initial begin
    #3;
    chk("rst_slots", slots, 0);
    chk("rst_fill", fill_count, 0);
    chk("rst_fv", frame_valid, 0);
    chk("rst_fp", frame_pulse, 0);
    chk("rst_te", timeout_err, 0);
    chk("rst_ready", in_ready, 1);
    tick();
    reset = 1'b0;
    send(8'h12);
    chk("w1_slots", slots, 24'h000012);
    chk("w1_fill", fill_count, 1);
    send(8'h34);
    send(8'h56);
    chk("full_slots", slots, 24'h563412);
    chk("full_fill", fill_count, 3);
    chk("full_fv", frame_valid, 1);
    chk("full_fp", frame_pulse, 1);
    chk("full_ready", in_ready, 0);
    n = 0;
    in_valid = 1'b1;
    in_data = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      n += int'(frame_pulse);
    end
    in_valid = 1'b0;
    chk("hold_pulses", n, 0);
    chk("hold_slots", slots, 24'h563412);
    chk("hold_fv", frame_valid, 1);
    consume = 1'b1;
    tick();
    consume = 1'b0;
    chk("cons_fv", frame_valid, 0);
    chk("cons_ready", in_ready, 1);
    chk("cons_fill", fill_count, 0);
    chk("cons_slots", slots, 24'h563412);
    send(8'hAA);
    chk("aa_slots", slots, 24'h5634AA);
    consume = 1'b1;
    tick();
    consume = 1'b0;
    chk("cons_fill_noeffect", fill_count, 1);
    send(8'hBB);
    chk("bb_fill", fill_count, 2);
    clear = 1'b1;
    send(8'h77);
    clear = 1'b0;
    chk("clr_fill", fill_count, 0);
    chk("clr_slots", slots, 0);
    send(8'h01);
    send(8'h02);
    send(8'h03);
    chk("f2_slots", slots, 24'h030201);
    chk("f2_fv", frame_valid, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clrfull_fv", frame_valid, 0);
    chk("clrfull_slots", slots, 0);
    chk("clrfull_ready", in_ready, 1);
    send(8'h44);
    chk("pre_arst_fill", fill_count, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_fill", fill_count, 0);
    chk("arst_slots", slots, 0);
    chk("arst_ready", in_ready, 1);
    #2 reset = 1'b0;
    tick();
`ifdef OPERAND_BANK_TIMEOUT_EN
    send(8'h99);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      n += int'(timeout_err);
      if (i < 9) tick();
    end
    tick();
    chk("to_early", n, 0);
    chk("to_fill_before", fill_count, 1);
    tick();
    chk("to_err", timeout_err, 1);
    chk("to_fill", fill_count, 0);
    chk("to_slots_kept", slots, 24'h000099);
    tick();
    chk("to_err_once", timeout_err, 0);
    send(8'h11);
    for (int i = 0; i < 10; i++) tick();
    send(8'h22);
    chk("to_race_fill", fill_count, 2);
    chk("to_race_err", timeout_err, 0);
    chk("to_race_slots", slots, 24'h002211);
`else
    send(8'h99);
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      n += int'(timeout_err);
    end
    chk("nto_fill", fill_count, 1);
    chk("nto_err", n, 0);
    chk("nto_slots", slots, 24'h000099);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
